multimem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port 256×8 data memory bank (synchronous write, combinational read) among `NUM_REQ` requesters, such as processing elements or a loader. It captures one request per cycle into an access stage, drives the bank's Address/WriteData/MemWrite/MemRead for exactly one cycle, and returns read data with a one-cycle Ack pulse. It sits between the requesters and one memory bank; one instance is used per bank.

---
 rtl/multimem_arbiter_pkg.sv | 14 +
 rtl/multimem_arbiter_rr_pick.sv | 27 ++
 rtl/multimem_arbiter.sv | 83 ++++++++
 tb/tb_multimem_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/multimem_arbiter_pkg.sv
// mem_arb_pkg: default bank widths, per-requester state encoding and the access-stage record
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int IDX_W = 3;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_ACKED = 2'd2;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    logic valid;
  } mem_access_t;
endpackage

// File: rtl/multimem_arbiter_rr_pick.sv
// rr_pick: masked round-robin picker; MEM_ARB_FIXED_PRIO_EN turns it into a lowest-index priority encoder
module rr_pick import mem_arb_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]     elig,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    idx = '0;
    gnt = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int j = N - 1; j >= 0; j--)
      if (elig[j]) idx = IDX_W'(j);
`else
    // scan offsets from farthest to nearest so the nearest eligible one wins
    for (int k = N - 1; k >= 0; k--)
      for (int j = 0; j < N; j++)
        if (elig[j] && j == (int'(ptr) + k) % N) idx = IDX_W'(j);
`endif
    for (int i = 0; i < N; i++)
      gnt[i] = |elig && idx == IDX_W'(i);
  end
endmodule

// File: rtl/multimem_arbiter.sv
// multimem_arbiter: shares one single-port bank among NUM_REQ requesters, one access per cycle, Ack two cycles after grant
// MEM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin
module multimem_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ-1:0]        We,
  input  logic [NUM_REQ*ADDR_W-1:0] Addr,
  input  logic [NUM_REQ*DATA_W-1:0] WData,
  output logic [NUM_REQ-1:0]        Ack,
  output logic [NUM_REQ*DATA_W-1:0] RData,
  output logic [ADDR_W-1:0]         Mem_Address,
  output logic [DATA_W-1:0]         Mem_WriteData,
  output logic                      Mem_MemWrite,
  output logic                      Mem_MemRead,
  input  logic [DATA_W-1:0]         Mem_ReadData
);
  logic [NUM_REQ-1:0][1:0] st;
  logic [NUM_REQ-1:0] pend, elig, gnt;
  logic [IDX_W-1:0] w_idx;
  logic sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  mem_access_t acc;

  always_comb begin
    pend = '0;
    Ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = st[i] != ST_IDLE;
      Ack[i] = st[i] == ST_ACKED;
    end
    elig = Req & ~pend;
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  rr_pick #(.N(NUM_REQ)) u_pick (.elig(elig), .gnt(gnt), .idx(w_idx));
`else
  logic [IDX_W-1:0] rr_ptr;
  rr_pick #(.N(NUM_REQ)) u_pick (.elig(elig), .ptr(rr_ptr), .gnt(gnt), .idx(w_idx));
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) rr_ptr <= '0;
    else if (|elig) rr_ptr <= w_idx == IDX_W'(NUM_REQ - 1) ? '0 : w_idx + 1'b1;
`endif

  always_comb begin
    sel_we = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        sel_we = We[i];
        sel_addr = Addr[i*ADDR_W +: ADDR_W];
        sel_wdata = WData[i*DATA_W +: DATA_W];
      end
  end

  // address/data only load on a grant so the bank sees stable values while idle
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) acc <= '0;
    else if (|elig) acc <= '{idx: w_idx, we: sel_we, addr: sel_addr, wdata: sel_wdata, valid: 1'b1};
    else acc.valid <= 1'b0;

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      st <= {NUM_REQ{ST_IDLE}};
      RData <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        st[i] <= gnt[i] ? ST_ACCESS : st[i] == ST_ACCESS ? ST_ACKED : ST_IDLE;
        if (acc.valid && !acc.we && acc.idx == IDX_W'(i)) RData[i*DATA_W +: DATA_W] <= Mem_ReadData;
      end
    end

  assign Mem_Address = acc.addr;
  assign Mem_WriteData = acc.wdata;
  assign Mem_MemWrite = acc.valid & acc.we;
  assign Mem_MemRead = acc.valid & ~acc.we;
endmodule

// File: tb/tb_multimem_arbiter.sv
// tb_multimem_arbiter: directed checks of multimem_arbiter against a 256x8 bank model
module tb_multimem_arbiter;
  logic Clk, Rst_n;
  logic [3:0] Req, We, Ack;
  logic [31:0] Addr, WData, RData;
  logic [7:0] Mem_Address, Mem_WriteData, Mem_ReadData;
  logic Mem_MemWrite, Mem_MemRead;
  logic [7:0] mem [256];
  logic pl_en;
  logic [7:0] pl_addr, pl_data;
  int checks, errors;

  multimem_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .We(We), .Addr(Addr), .WData(WData),
    .Ack(Ack), .RData(RData), .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
    .Mem_MemWrite(Mem_MemWrite), .Mem_MemRead(Mem_MemRead), .Mem_ReadData(Mem_ReadData)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  always @(posedge Clk)
    if (Mem_MemWrite) mem[Mem_Address] <= Mem_WriteData;
    else if (pl_en) mem[pl_addr] <= pl_data;
  assign Mem_ReadData = mem[Mem_Address];

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    Req[i] = 1'b1; We[i] = w; Addr[i*8 +: 8] = a; WData[i*8 +: 8] = d;
  endtask

  task automatic test_reset;
    checks++; if (Ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b exp 0000", Ack); end
    checks++; if (RData !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", RData); end
    checks++; if ({Mem_MemWrite, Mem_MemRead} !== 2'b00) begin errors++; $display("FAIL reset_memctl got %b exp 00", {Mem_MemWrite, Mem_MemRead}); end
    checks++; if ({Mem_Address, Mem_WriteData} !== 16'h0) begin errors++; $display("FAIL reset_memaddr got %h exp 0", {Mem_Address, Mem_WriteData}); end
  endtask

  task automatic test_single_read;
    set_req(0, 1'b0, 8'h10, 8'h00);
    tick();
    Req = 0;
    checks++; if ({Mem_MemRead, Mem_MemWrite, Mem_Address} !== {2'b10, 8'h10}) begin errors++; $display("FAIL rd_access got %b/%h exp 10/10", {Mem_MemRead, Mem_MemWrite}, Mem_Address); end
    checks++; if (Ack !== 4'b0000) begin errors++; $display("FAIL rd_early_ack got %b exp 0000", Ack); end
    tick();
    checks++; if (Ack !== 4'b0001) begin errors++; $display("FAIL rd_ack got %b exp 0001", Ack); end
    checks++; if (RData[7:0] !== 8'h5A) begin errors++; $display("FAIL rd_data got %h exp 5a", RData[7:0]); end
    tick();
    checks++; if (Ack !== 4'b0000 || RData[7:0] !== 8'h5A) begin errors++; $display("FAIL rd_hold got %b/%h exp 0000/5a", Ack, RData[7:0]); end
  endtask

  task automatic test_write_read;
    set_req(1, 1'b1, 8'h20, 8'hC3);
    tick();
    Req = 0;
    set_req(2, 1'b0, 8'h20, 8'h00);
    checks++; if ({Mem_MemWrite, Mem_MemRead, Mem_Address, Mem_WriteData} !== {2'b10, 8'h20, 8'hC3}) begin errors++; $display("FAIL wr_access got %b %h %h exp 10 20 c3", {Mem_MemWrite, Mem_MemRead}, Mem_Address, Mem_WriteData); end
    tick();
    Req = 0;
    checks++; if ({Mem_MemRead, Mem_Address, Ack} !== {1'b1, 8'h20, 4'b0010}) begin errors++; $display("FAIL raw_access got %b %h %b exp 1 20 0010", Mem_MemRead, Mem_Address, Ack); end
    tick();
    checks++; if (Ack !== 4'b0100) begin errors++; $display("FAIL raw_ack got %b exp 0100", Ack); end
    checks++; if (RData[23:16] !== 8'hC3) begin errors++; $display("FAIL raw_data got %h exp c3", RData[23:16]); end
    tick();
  endtask

  task automatic test_idle;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if ({Mem_MemWrite, Mem_MemRead, Ack} !== 6'b0) begin errors++; $display("FAIL idle_c%0d got %b %b exp 00 0000", c, {Mem_MemWrite, Mem_MemRead}, Ack); end
    end
    checks++; if (Mem_Address !== 8'h20) begin errors++; $display("FAIL idle_addr_hold got %h exp 20", Mem_Address); end
  endtask

  task automatic test_fairness;
    int exp_g [8];
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 1, 2, 0, 1, 2, 0, 1};
`else
    exp_g = '{3, 0, 1, 2, 3, 0, 1, 2};
`endif
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h40 + 8'(i), 8'h00);
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if ({Mem_MemRead, Mem_MemWrite, Mem_Address} !== {2'b10, 8'h40 + 8'(exp_g[k])}) begin errors++; $display("FAIL fair_%0d got %b %h exp 10 %h", k, {Mem_MemRead, Mem_MemWrite}, Mem_Address, 8'h40 + 8'(exp_g[k])); end
    end
    Req = 0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back;
    set_req(0, 1'b0, 8'h10, 8'h00);
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++; if (Mem_MemRead !== (c == 1 || c == 4 || c == 7)) begin errors++; $display("FAIL b2b_rd_c%0d got %b", c, Mem_MemRead); end
      checks++; if (Ack !== ((c == 2 || c == 5 || c == 8) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL b2b_ack_c%0d got %b", c, Ack); end
      if (c == 8) Req = 0;
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_write;
    set_req(0, 1'b1, 8'h30, 8'hFF);
    tick();
    checks++; if (Mem_MemWrite !== 1'b1) begin errors++; $display("FAIL rst_pre_write got %b exp 1", Mem_MemWrite); end
    #1 Rst_n = 0;
    Req = 0;
    #1;
    checks++; if ({Mem_MemWrite, Mem_MemRead, Mem_Address, Mem_WriteData} !== 18'h0) begin errors++; $display("FAIL rst_async_mem got %b %h %h exp 00 00 00", {Mem_MemWrite, Mem_MemRead}, Mem_Address, Mem_WriteData); end
    checks++; if ({Ack, RData} !== 36'h0) begin errors++; $display("FAIL rst_async_out got %b %h exp 0 0", Ack, RData); end
    tick();
    checks++; if (mem[8'h30] !== 8'h11) begin errors++; $display("FAIL rst_no_commit got %h exp 11", mem[8'h30]); end
    tick();
    #1 Rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (Ack !== 4'b0) begin errors++; $display("FAIL rst_no_ack_c%0d got %b exp 0000", c, Ack); end
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h50 + 8'(i), 8'h00);
    tick();
    Req = 0;
    checks++; if ({Mem_MemRead, Mem_Address} !== {1'b1, 8'h50}) begin errors++; $display("FAIL rst_first_prio got %b %h exp 1 50", Mem_MemRead, Mem_Address); end
    repeat (4) tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    Rst_n = 0; Req = 0; We = 0; Addr = 0; WData = 0;
    pl_en = 0; pl_addr = 0; pl_data = 0;
    preload(8'h10, 8'h5A);
    preload(8'h30, 8'h11);
    test_reset();
    tick();
    #1 Rst_n = 1;
    tick();
    test_single_read();
    test_write_read();
    test_idle();
    test_fairness();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
